// File: rtl/serial_tx_pkg.sv
//==============================================================================
// Module   : serial_tx_pkg
// Purpose  : State type and encodings shared by the serial word transmitter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package serial_tx_pkg;

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_SEND   = 2'd1;
    localparam logic [1:0] C_ST_PARITY = 2'd2;
    localparam logic [1:0] C_ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = C_ST_IDLE,
        SEND   = C_ST_SEND,
        PARITY = C_ST_PARITY,
        DONE   = C_ST_DONE
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/ShiftRegister_PIPO.sv
//==============================================================================
// Module   : ShiftRegister_PIPO
// Purpose  : Parallel-load shift register; shifts left or right by one when en.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ShiftRegister_PIPO #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic             left,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= D;
        end else if (en) begin
            r_q <= left ? {r_q[WIDTH-2:0], 1'b0} : {1'b0, r_q[WIDTH-1:1]};
        end
    end

    assign Q = r_q;

endmodule

`default_nettype wire

// File: rtl/serial_word_tx.sv
//==============================================================================
// Module   : serial_word_tx
// Purpose  : Parallel-to-serial word transmitter with load/ready handshake.
//            Optional even-parity trailer bit when SERIAL_TX_PARITY_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_word_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             left,
    output logic             ready,
    output logic             serial,
    output logic             en,
    output logic             done
);

    import serial_tx_pkg::*;

    localparam int               CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]    C_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] C_MSB  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] C_LSB  = {{(WIDTH-1){1'b0}}, 1'b1};

    tx_state_t        r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_left;
    logic             r_ready;
    logic             r_en;
    logic             r_done;
    logic             w_accept;
    logic             w_bit;
    logic [WIDTH-1:0] w_q;
`ifdef SERIAL_TX_PARITY_EN
    logic             r_parity;
`endif

    // Reset beats a simultaneous load so the word is never captured.
    assign w_accept = load & r_ready & ~reset;

    ShiftRegister_PIPO #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clock (clock),
        .reset (reset),
        .load  (w_accept),
        .en    (r_state == SEND),
        .left  (r_left),
        .D     (data),
        .Q     (w_q)
    );

    // Masked reduction selects the outgoing end of the register.
    assign w_bit = |(w_q & (r_left ? C_MSB : C_LSB));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_left   <= 1'b0;
            r_ready  <= 1'b1;
            r_en     <= 1'b0;
            r_done   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state  <= SEND;
                        r_cnt    <= '0;
                        r_left   <= left;
                        r_ready  <= 1'b0;
                        r_en     <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                        r_parity <= ^data;
`endif
                    end
                end
                SEND: begin
                    if (r_cnt == C_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                        r_state <= PARITY;
`else
                        r_state <= DONE;
                        r_en    <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    r_state <= DONE;
                    r_en    <= 1'b0;
                    r_done  <= 1'b1;
                end
`endif
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_en    <= 1'b0;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign en    = r_en;
    assign done  = r_done;
`ifdef SERIAL_TX_PARITY_EN
    assign serial = r_en & ((r_state == PARITY) ? r_parity : w_bit);
`else
    assign serial = r_en & w_bit;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_word_tx.sv
//==============================================================================
// Module   : tb_serial_word_tx
// Purpose  : Self-checking bench for serial_word_tx against a word-level model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_word_tx;

    localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         load  = 1'b0;
    logic         left  = 1'b0;
    logic [W-1:0] data  = '0;
    logic         ready;
    logic         serial;
    logic         en;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    serial_word_tx #(
        .WIDTH (W)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .data   (data),
        .load   (load),
        .left   (left),
        .ready  (ready),
        .serial (serial),
        .en     (en),
        .done   (done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // i-th bit on the wire for a word sent in the given direction
    function automatic logic exp_bit(input logic [W-1:0] d, input bit l, input int i);
        return l ? d[W-1-i] : d[i];
    endfunction

    task automatic idle_check(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            check_eq("idle_en", en, 1'b0);
            check_eq("idle_done", done, 1'b0);
            check_eq("idle_ready", ready, 1'b1);
        end
    endtask

    // Called at a negedge while idle; returns at a negedge with ready high.
    task automatic tx_word(input logic [W-1:0] d, input bit l, input bit inject, input int rst_at);
        logic [W-1:0] rx;
        logic         e_en, e_ser, e_done, e_rdy;
        int           n_total;
        rx      = '0;
        n_total = W + PAR + 2;
        check_eq("ready_before_load", ready, 1'b1);
        data = d;
        left = l;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        data = W'($urandom);
        left = 1'($urandom);
        for (int c = 1; c <= n_total; c++) begin
            e_en   = (c <= W + PAR);
            e_done = (c == W + PAR + 1);
            e_rdy  = (c == n_total);
            if (c <= W)                  e_ser = exp_bit(d, l, c - 1);
            else if (c == W + 1 && PAR == 1) e_ser = ^d;
            else                         e_ser = 1'b0;
            check_eq("en", en, e_en);
            check_eq("serial_bit", serial, e_ser);
            check_eq("done", done, e_done);
            check_eq("ready", ready, e_rdy);
            if (c <= W && en) rx = l ? {rx[W-2:0], serial} : {serial, rx[W-1:1]};
            if (c == W + PAR + 1) check_eq("loopback_word", rx, d);
            if (c == rst_at) begin
                reset = 1'b1;
                load  = 1'b1;
                data  = W'(8'hAA);
                @(negedge clock);
                reset = 1'b0;
                load  = 1'b0;
                check_eq("abort_ready", ready, 1'b1);
                check_eq("abort_en", en, 1'b0);
                check_eq("abort_serial", serial, 1'b0);
                check_eq("abort_done", done, 1'b0);
                idle_check(W + 3);
                return;
            end
            if (c == n_total) break;
            load = inject && (c == 3);
            if (load) begin
                data = W'(8'h77);
                left = ~l;
            end
            @(negedge clock);
        end
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b1;
        data  = W'(8'hFF);
        repeat (2) @(negedge clock);
        check_eq("rst_ready", ready, 1'b1);
        check_eq("rst_en", en, 1'b0);
        check_eq("rst_serial", serial, 1'b0);
        check_eq("rst_done", done, 1'b0);
        reset = 1'b0;
        load  = 1'b0;
        idle_check(2);

        tx_word(W'(8'hC1), 1'b1, 1'b0, 0);
        tx_word(W'(8'hC1), 1'b0, 1'b0, 0);
        tx_word(W'(8'h03), 1'b1, 1'b0, 0);
        tx_word(W'(8'h5A), 1'b1, 1'b0, 0);
        tx_word(W'(8'hFF), 1'b1, 1'b0, 0);
        tx_word(W'(8'h00), 1'b1, 1'b0, 0);
        tx_word(W'(8'h5A), 1'b0, 1'b0, 0);
        tx_word(W'(8'hC1), 1'b1, 1'b1, 0);
        idle_check(3);
        tx_word(W'(8'hC1), 1'b1, 1'b0, 4);
        tx_word(W'(8'h81), 1'b1, 1'b0, 0);
        tx_word(W'(8'h81), 1'b0, 1'b0, 0);
        for (int i = 0; i < 24; i++) begin
            tx_word(W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, W + PAR + 1)) : 0);
        end
        idle_check(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_word_tx.md
# serial_word_tx

Parallel-to-serial word transmitter. It is the sending end of the serial link whose receiving end is `ShiftRegister_SIPO`. It accepts a WIDTH-bit word through a load/ready handshake and shifts it out one bit per clock, MSB-first or LSB-first. For every valid bit it drives a shift strobe that connects directly to the receiver's `en`. It sits between a word-producing datapath and any SIPO receiver in the design.

## Interface
- WIDTH, 8, word width in bits (≥ 2)
- clock  input  1  system clock, all state updates on posedge
- reset  input  1  synchronous, active-high; returns block to IDLE
- data  input  WIDTH  word to send, sampled on accepted load
- load  input  1  request to start a transfer; accepted only when `ready` = 1
- left  input  1  direction, sampled with `data`: 1 = MSB-first (pairs with receiver `left` = 1), 0 = LSB-first
- ready  output  1  high only in IDLE
- serial  output  1  current bit; 0 whenever `en` = 0
- en  output  1  high for exactly one cycle per transmitted bit
- done  output  1  one-cycle pulse after the last bit

## Operation
- States:
  - IDLE: `ready` = 1; `load` → SEND and capture `data`/`left`.
  - SEND: shift one bit per cycle; after WIDTH bits → PARITY if enabled, else DONE.
  - PARITY: one cycle only → DONE.
  - DONE: one cycle, `done` = 1 → IDLE.
- Accepted load (`load` & `ready` at an edge):
  - shift register ← `data`, direction latch ← `left`, bit counter ← 0.
- In SEND:
  - `serial` = shreg[WIDTH-1] if latched left, else shreg[0].
  - Each edge shifts the register toward the output bit and increments the counter.
  - Leave SEND on the edge where the counter reaches WIDTH-1.
- Bit counter width is $clog2(WIDTH); it never wraps within a transfer.
- `load` while `ready` = 0 is ignored; it is neither queued nor sticky.
- `data`/`left` changes after acceptance have no effect on the word in flight.
- `reset` at any state: next edge → IDLE. Outputs go to reset values and no `done` pulse occurs for the aborted word.
- `reset` and `load` asserted together: reset wins and the word is not captured.

## Timing
- Reset values: `ready` = 1, `serial` = 0, `en` = 0, `done` = 0.
- `ready`, `serial`, `en` and `done` are decoded only from registered state, shift register and latches. There is no combinational path from any input to any output.
- Load accepted at edge k:
  - cycles k+1 … k+WIDTH: `en` = 1, one bit each;
  - with parity: cycle k+WIDTH+1 carries the parity bit;
  - following cycle: `done` = 1, `ready` = 0;
  - next cycle: `ready` = 1.
- Throughput: one word per WIDTH+2 cycles (WIDTH+3 with parity).
- `ready` falls the cycle after acceptance and stays low through DONE.
- A receiver sharing `clock` shifts on the same edges, so its word is complete at the edge that ends the last `en` cycle.

## Configuration
- Macro `SERIAL_TX_PARITY_EN`.
- Defined:
  - Parity bit = XOR of all `data` bits, computed at load (even parity).
  - Sent in the PARITY state with `en` = 1, after the last data bit regardless of direction.
- Undefined:
  - PARITY state and parity register are absent; SEND goes directly to DONE.

## Structure
- Package `serial_tx_pkg`:
  - `typedef enum logic [1:0] {IDLE, SEND, PARITY, DONE} tx_state_t`
  - encoding constants
- The shift register is one instance of the existing `ShiftRegister_PIPO`:
  - `load` = accepted load
  - `en` = (state == SEND)
  - `left` = latched direction
- The bit counter, FSM, direction latch and parity register live in `serial_word_tx`. No other sub-modules.

## Test plan
- WIDTH = 8, `data` = 8'hC1, `left` = 1, load at cycle 0 → `serial` = 1,1,0,0,0,0,0,1 on cycles 1–8 with `en` = 1; `done` = 1 at cycle 9; `ready` = 1 at cycle 10.
- Same as above with `left` = 0 → `serial` = 1,0,0,0,0,0,1,1 on cycles 1–8.
- With `SERIAL_TX_PARITY_EN`, `data` = 8'hC1 → parity bit 1 at cycle 9 with `en` = 1; `done` at cycle 10. With `data` = 8'h03 → parity bit 0.
- Loopback into `ShiftRegister_SIPO` (same `clock`, `left` tied equal): back-to-back words 8'h5A, 8'hFF, 8'h00 → receiver `Q` equals each word at its `done` cycle.
- Pulse `load` with 8'h77 at cycle 3 of a transfer of 8'hC1 → ignored; the C1 bit sequence is unchanged and no second transfer starts.
- Assert `reset` at cycle 4 of a transfer → next cycle `ready` = 1 and `en` = `serial` = `done` = 0; no `done` pulse occurs; a new load of 8'h81 afterward transmits correctly.
